// File: rtl/scroll_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scroll_pkg
//  Description : Shared state encoding, rate defaults and accumulator width
//                for the scrolling-message step controller.
//  Revision    : 1.0  initial release
// ============================================================================
package scroll_pkg;

    // Phase accumulator width; must hold any CLK_HZ value used
    localparam int ACC_W        = 27;
    // Width of the steps-per-second rate register
    localparam int RATE_W       = 6;

    // Rate bounds and post-reset value
    localparam int RATE_MIN_DEF = 1;
    localparam int RATE_MAX_DEF = 50;
    localparam int RATE_RST_DEF = 3;

    // Controller state, also shown on the LEDs
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/scroll_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : One pushbutton: two-flop synchronizer, stable-time debounce
//                and a one-cycle press pulse on the debounced 1->0 edge.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce #(
    parameter int DB_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int               CNT_W    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;

    // Bring the raw button into the clock domain; idle (released) is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Flip the debounced level once the input has disagreed for DB_CYC clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scroll_ctrl
//  Description : Scrolling-display controller. Debounced keys adjust a
//                steps-per-second rate; a fractional phase accumulator emits
//                drift-free step pulses while a LOAD/RUN/PAUSE FSM gates it.
//  Revision    : 1.0  initial release
// ============================================================================
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int DB_CYC   = 1000000,
    parameter int RATE_RST = RATE_RST_DEF,
    parameter int RATE_MIN = RATE_MIN_DEF,
    parameter int RATE_MAX = RATE_MAX_DEF
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [3:0]        KEY,
    input  logic [1:0]        SW,
    output logic              load,
    output logic              step,
    output logic              dir,
    output logic [RATE_W-1:0] rate,
    output logic [1:0]        state
);

    localparam int                SUM_W      = ACC_W + 1;
    localparam logic [SUM_W-1:0]  C_LIMIT    = SUM_W'(CLK_HZ);
    localparam logic [RATE_W-1:0] C_RATE_RST = RATE_W'(RATE_RST);
    localparam logic [RATE_W-1:0] C_RATE_MIN = RATE_W'(RATE_MIN);
    localparam logic [RATE_W-1:0] C_RATE_MAX = RATE_W'(RATE_MAX);

    logic [3:0]        w_press;
    logic [1:0]        r_sw1;
    logic [1:0]        r_sw2;
    state_t            r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [RATE_W-1:0] r_rate;
    logic              r_load;
    logic              r_step;
    logic              r_dir;
    logic [SUM_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_diff;

    // One debouncer per pushbutton
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        key_debounce #(
            .DB_CYC (DB_CYC)
        ) u_key (
            .clk   (CLOCK_50),
            .rst   (RESET),
            .key_n (KEY[gi]),
            .press (w_press[gi])
        );
    end

    // Next accumulator value and its wrapped remainder (fits in ACC_W bits
    // because acc < CLK_HZ before the add)
    assign w_sum  = {1'b0, r_acc} + {{(SUM_W - RATE_W){1'b0}}, r_rate};
    assign w_diff = w_sum[ACC_W-1:0] - C_LIMIT[ACC_W-1:0];

    // Switch synchronizer; reset value selects load mode until SW is seen
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_sw1 <= 2'b11;
            r_sw2 <= 2'b11;
        end else begin
            r_sw1 <= SW;
            r_sw2 <= r_sw1;
        end
    end

    // Rate register: reset key beats increment beats decrement
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_rate <= C_RATE_RST;
        end else if (w_press[0]) begin
            r_rate <= C_RATE_RST;
        end else if (w_press[1]) begin
            if (r_rate < C_RATE_MAX) begin
                r_rate <= r_rate + 1'b1;
            end
        end else if (w_press[2]) begin
            if (r_rate > C_RATE_MIN) begin
                r_rate <= r_rate - 1'b1;
            end
        end
    end

    // Direction only follows the switch between steps
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_dir <= 1'b0;
        end else if (!r_step) begin
            r_dir <= r_sw2[1];
        end
    end

    // LOAD/RUN/PAUSE control with the phase accumulator and step pulse
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_LOAD;
            r_load  <= 1'b1;
            r_step  <= 1'b0;
            r_acc   <= '0;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    r_step <= 1'b0;
                    r_acc  <= '0;
                    if (r_sw2[0]) begin
                        r_load <= 1'b1;
                    end else begin
                        r_load  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_sw2[0]) begin
                        // Load request wins over a simultaneous pause key
                        r_state <= ST_LOAD;
                        r_load  <= 1'b1;
                        r_step  <= 1'b0;
                        r_acc   <= '0;
                    end else if (w_press[3]) begin
                        r_state <= ST_PAUSE;
                        r_step  <= 1'b0;
                    end else if (w_sum >= C_LIMIT) begin
                        r_step <= 1'b1;
                        r_acc  <= w_diff;
                    end else begin
                        r_step <= 1'b0;
                        r_acc  <= w_sum[ACC_W-1:0];
                    end
                end
                ST_PAUSE: begin
                    r_step <= 1'b0;
                    if (r_sw2[0]) begin
                        r_state <= ST_LOAD;
                        r_load  <= 1'b1;
                        r_acc   <= '0;
                    end else if (w_press[3]) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                    r_load  <= 1'b1;
                    r_step  <= 1'b0;
                    r_acc   <= '0;
                end
            endcase
        end
    end

    assign load  = r_load;
    assign step  = r_step;
    assign dir   = r_dir;
    assign rate  = r_rate;
    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scroll_ctrl
//  Description : Self-checking bench for scroll_ctrl with a behavioural model
//                and directed key/switch scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scroll_ctrl;

    localparam int CLK_HZ   = 100;
    localparam int DB_CYC   = 4;
    localparam int RATE_RST = 3;
    localparam int RATE_MIN = 1;
    localparam int RATE_MAX = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic [1:0] sw;
    logic       load;
    logic       step;
    logic       dir;
    logic [5:0] rate;
    logic [1:0] state;

    int errors     = 0;
    int checks     = 0;
    int cyc        = 0;
    int step_count = 0;
    int step_times[$];

    scroll_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .DB_CYC   (DB_CYC),
        .RATE_RST (RATE_RST),
        .RATE_MIN (RATE_MIN),
        .RATE_MAX (RATE_MAX)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .KEY      (key),
        .SW       (sw),
        .load     (load),
        .step     (step),
        .dir      (dir),
        .rate     (rate),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Free-running cycle count
    always @(posedge clk) cyc++;

    // ---------------- behavioural model ----------------
    int                m_rate;
    int                m_state;
    int                m_acc;
    logic              m_load;
    logic              m_step;
    logic              m_dir;
    logic [1:0]        m_sw_a;
    logic [1:0]        m_sw_b;
    logic [3:0]        m_key_a;
    logic [3:0]        m_key_b;
    logic [3:0]        m_lvl;
    logic [3:0]        m_ev;
    logic [DB_CYC-1:0] m_win[4];

    // Model: one update per clock, using the values held before the edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rate  = RATE_RST;
            m_state = 0;
            m_acc   = 0;
            m_load  = 1'b1;
            m_step  = 1'b0;
            m_dir   = 1'b0;
            m_sw_a  = 2'b11;
            m_sw_b  = 2'b11;
            m_key_a = 4'hF;
            m_key_b = 4'hF;
            m_lvl   = 4'hF;
            m_ev    = 4'h0;
            for (int k = 0; k < 4; k++) m_win[k] = '1;
        end else begin
            if (!m_step) m_dir = m_sw_b[1];
            case (m_state)
                0: begin
                    m_step = 1'b0;
                    m_acc  = 0;
                    if (m_sw_b[0]) m_load = 1'b1;
                    else begin m_load = 1'b0; m_state = 1; end
                end
                1: begin
                    if (m_sw_b[0]) begin
                        m_state = 0; m_load = 1'b1; m_step = 1'b0; m_acc = 0;
                    end else if (m_ev[3]) begin
                        m_state = 2; m_step = 1'b0;
                    end else begin
                        m_acc  = m_acc + m_rate;
                        m_step = (m_acc >= CLK_HZ);
                        if (m_step) m_acc = m_acc - CLK_HZ;
                    end
                end
                default: begin
                    m_step = 1'b0;
                    if (m_sw_b[0]) begin
                        m_state = 0; m_load = 1'b1; m_acc = 0;
                    end else if (m_ev[3]) begin
                        m_state = 1;
                    end
                end
            endcase
            if (m_ev[0])      m_rate = RATE_RST;
            else if (m_ev[1]) m_rate = (m_rate + 1 > RATE_MAX) ? RATE_MAX : m_rate + 1;
            else if (m_ev[2]) m_rate = (m_rate - 1 < RATE_MIN) ? RATE_MIN : m_rate - 1;
            // A key level flips when the last DB_CYC synchronized samples all disagree
            for (int k = 0; k < 4; k++) begin
                m_win[k] = {m_win[k][DB_CYC-2:0], m_key_b[k]};
                m_ev[k]  = 1'b0;
                if (m_win[k] == {DB_CYC{~m_lvl[k]}}) begin
                    m_lvl[k] = ~m_lvl[k];
                    m_ev[k]  = ~m_lvl[k];
                end
            end
            m_key_b = m_key_a;
            m_key_a = key;
            m_sw_b  = m_sw_a;
            m_sw_a  = sw;
        end
    end

    // Compare DUT against the model on every clock outside reset
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (load !== m_load || step !== m_step || dir !== m_dir ||
                rate !== 6'(m_rate) || state !== 2'(m_state)) begin
                errors++;
                $display("FAIL model cyc=%0d got load=%b step=%b dir=%b rate=%0d state=%0d want load=%b step=%b dir=%b rate=%0d state=%0d",
                         cyc, load, step, dir, rate, state, m_load, m_step, m_dir, m_rate, m_state);
            end
            if (step === 1'b1) begin
                step_times.push_back(cyc);
                step_count++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k);
        key[k] = 1'b0;
        tick(10);
        key[k] = 1'b1;
        tick(10);
    endtask

    task automatic wait_state(input int want, input int bound, output int n);
        n = 0;
        while (int'(state) != want && n < bound) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_steps(input int cnt, input int bound);
        int n;
        n = 0;
        while (step_times.size() < cnt && n < bound) begin
            tick(1);
            n++;
        end
        check("steps_arrived", (step_times.size() >= cnt) ? 1 : 0, 1);
    endtask

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        int t0;
        int s0;

        rst = 1'b1;
        key = 4'hF;
        sw  = 2'b01;
        tick(3);
        check("reset_state", int'(state), 0);
        check("reset_load",  int'(load),  1);
        check("reset_step",  int'(step),  0);
        check("reset_dir",   int'(dir),   0);
        check("reset_rate",  int'(rate),  3);
        rst = 1'b0;

        // Held in load mode while SW[0]=1
        tick(10);
        check("load_hold_state", int'(state), 0);
        check("load_hold_load",  int'(load),  1);

        // Release load: RUN after the two synchronizer stages plus the FSM
        sw = 2'b00;
        wait_state(1, 8, n);
        check("run_entry_lat", n, 3);
        t0 = cyc;
        step_times.delete();
        wait_steps(3, 150);
        if (step_times.size() >= 3) begin
            check("first_step", step_times[0] - t0, 34);
            check("step_gap1",  step_times[1] - step_times[0], 33);
            check("step_gap2",  step_times[2] - step_times[1], 33);
        end

        // Long hold gives exactly one increment
        key[1] = 1'b0;
        tick(50);
        key[1] = 1'b1;
        tick(10);
        check("hold_one_event", int'(rate), 4);

        for (int i = 0; i < 60; i++) press(1);
        check("rate_sat_max", int'(rate), 50);
        for (int i = 0; i < 60; i++) press(2);
        check("rate_sat_min", int'(rate), 1);
        for (int i = 0; i < 9; i++) press(1);
        check("rate_ten", int'(rate), 10);

        // KEY[0] and KEY[1] together: reset wins
        key = 4'b1100;
        tick(10);
        key = 4'b1111;
        tick(10);
        check("key0_over_key1", int'(rate), 3);

        // Short glitch is filtered out
        key[2] = 1'b0;
        tick(2);
        key[2] = 1'b1;
        tick(12);
        check("glitch_ignored", int'(rate), 3);

        // Rotate right
        sw[1] = 1'b1;
        tick(6);
        check("dir_right", int'(dir), 1);

        // Pause and resume
        check("in_run", int'(state), 1);
        key[3] = 1'b0;
        wait_state(2, 20, n);
        check("pause_entry", int'(state), 2);
        tick(5);
        key[3] = 1'b1;
        tick(10);
        s0 = step_count;
        tick(500);
        check("pause_no_step", step_count - s0, 0);
        check("pause_state", int'(state), 2);
        key[3] = 1'b0;
        wait_state(1, 20, n);
        check("resume_state", int'(state), 1);
        s0 = step_count;
        n  = 0;
        while (step_count == s0 && n < 40) begin
            tick(1);
            n++;
        end
        check("resume_step_seen", (step_count > s0) ? 1 : 0, 1);
        key[3] = 1'b1;
        tick(10);

        // Load mode from RUN
        sw[0] = 1'b1;
        n = 0;
        while (load !== 1'b1 && n < 8) begin
            tick(1);
            n++;
        end
        check("load_entry_lat", n, 3);
        check("load_state", int'(state), 0);
        s0 = step_count;
        tick(50);
        check("load_no_step", step_count - s0, 0);
        sw[0] = 1'b0;
        wait_state(1, 8, n);
        check("rerun_lat", n, 3);

        // Raise the rate to 20, then reset asynchronously mid-count
        for (int i = 0; i < 17; i++) press(1);
        check("rate_twenty", int'(rate), 20);
        tick(13);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rate",  int'(rate),  3);
        check("async_rst_state", int'(state), 0);
        check("async_rst_load",  int'(load),  1);
        check("async_rst_step",  int'(step),  0);
        tick(2);
        rst = 1'b0;

        // Fresh accumulator: first step a full 34 clocks after RUN entry
        wait_state(1, 8, n);
        check("post_rst_run_lat", n, 3);
        t0 = cyc;
        step_times.delete();
        wait_steps(1, 60);
        if (step_times.size() >= 1) begin
            check("post_rst_first_step", step_times[0] - t0, 34);
        end

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scroll_ctrl.md
SCROLL_CTRL -- requirements
Module: scroll_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000: tick period in clocks (one display step per second at rate 1).
REQ-002 Parameter DB_CYC, default 1000000: debounce stable-time in clocks (20 ms).
REQ-003 Parameter RATE_RST, default 3: rate after reset or KEY[0].
REQ-004 Parameters RATE_MIN, default 1, and RATE_MAX, default 50: rate saturation bounds.
REQ-005 CLOCK_50  input  1: single clock, rising edge.
REQ-006 RESET  input  1: asynchronous, active-high reset.
REQ-007 KEY  input  4: raw pushbuttons, active-low, asynchronous to CLOCK_50.
REQ-008 SW  input  2: SW[0]=1 holds message (load mode); SW[1]: 0 rotate left, 1 rotate right.
REQ-009 load  output  1: level, high while display datapath holds the fixed message.
REQ-010 step  output  1: one-cycle pulse commanding one digit rotation.
REQ-011 dir  output  1: rotation direction qualifying step; equals registered SW[1].
REQ-012 rate  output  6: current steps-per-second value.
REQ-013 state  output  2: FSM state for LEDs (LOAD=0, RUN=1, PAUSE=2).

Function
REQ-014 Each KEY bit SHALL pass a 2-flop synchronizer then a debouncer; debounced level changes only after input stable for DB_CYC consecutive clocks.
REQ-015 A press event SHALL be a one-cycle pulse on debounced 1->0 transition; holding a key yields exactly one event.
REQ-016 Rate: KEY[0] event -> RATE_RST; KEY[1] event -> rate+1 saturating at RATE_MAX; KEY[2] event -> rate-1 saturating at RATE_MIN.
REQ-017 Simultaneous rate events SHALL resolve by priority KEY[0] > KEY[1] > KEY[2]; lower ones discarded.
REQ-018 Rate updates SHALL be accepted in every FSM state and take effect on the next accumulator add.
REQ-019 Accumulator: 27-bit acc; in RUN, each clock acc <= acc + rate; when acc + rate >= CLK_HZ, step=1 that cycle and acc <= acc + rate - CLK_HZ (remainder kept, no drift).
REQ-020 FSM LOAD: load=1, step=0, acc held at 0; exit to RUN when registered SW[0]=0.
REQ-021 FSM RUN: load=0; KEY[3] event -> PAUSE; SW[0]=1 -> LOAD (SW[0] wins over KEY[3] same cycle).
REQ-022 FSM PAUSE: load=0, step=0, acc frozen; KEY[3] event -> RUN resuming from frozen acc; SW[0]=1 -> LOAD.
REQ-023 Step SHALL never be asserted in the same cycle load=1, and at most once per clock.
REQ-024 SW inputs SHALL be 2-flop synchronized; dir changes only between steps (sampled into dir on cycles with step=0).
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 RESET high SHALL immediately force: state=LOAD, load=1, step=0, dir=0, rate=RATE_RST, acc=0, debounced levels=1 (released), synchronizers=1.
REQ-027 Reset asserted mid-count SHALL discard acc remainder and any pending press events.
REQ-028 After RESET deasserts, first step in RUN SHALL occur no earlier than ceil(CLK_HZ/rate) clocks after entering RUN.

Structure
REQ-029 Shared package scroll_pkg: state encoding constants (LOAD, RUN, PAUSE), RATE_MIN/RATE_MAX/RATE_RST defaults, accumulator width.
REQ-030 One sub-module key_debounce (sync + debounce + falling-edge pulse, one bit), instantiated four times.
REQ-031 Accumulator, rate register and FSM SHALL reside in scroll_ctrl.

Verification (CLK_HZ=100, DB_CYC=4 for sim)
REQ-032 Reset, SW=00: load 1 while SW[0]... release -> state RUN in 2-3 clocks; steps every 34,33,33 clocks (rate 3, remainder carried), average 33.33.
REQ-033 KEY[1] held low 50 clocks -> exactly one event, rate 3->4; 60 KEY[1] presses -> rate stops at 50; 60 KEY[2] presses -> rate stops at 1.
REQ-034 KEY[0] and KEY[1] pressed same cycle with rate=10 -> rate=3, no increment.
REQ-035 KEY[3] press in RUN -> PAUSE, no step for 500 clocks; second press -> RUN, next step when frozen acc completes.
REQ-036 SW[0]=1 while RUN -> LOAD within 3 clocks, load=1, step never asserted; RESET pulsed mid-run with rate=20 -> rate=3, acc=0, state LOAD asynchronously.
REQ-037 2-cycle glitch on KEY[2] (< DB_CYC) -> no event, rate unchanged.
